// File: rtl/avionics_uart_pkg.sv
// Shared definitions for the avionics UART (uart_tx today, uart_rx later).
// Contents:
//   - 2-bit state encodings and the FSM state type
//   - default clock cycles per serial bit (50 MHz / 1 Mbaud)
//   - frame length in bits for 8N1 (start + 8 data + stop)
package avionics_uart_pkg;

    localparam logic [1:0] IDLE_ENC  = 2'd0;
    localparam logic [1:0] START_ENC = 2'd1;
    localparam logic [1:0] DATA_ENC  = 2'd2;
    localparam logic [1:0] STOP_ENC  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = IDLE_ENC,
        START = START_ENC,
        DATA  = DATA_ENC,
        STOP  = STOP_ENC
    } state_t;

    localparam int DEFAULT_CLK_PER_BIT = 50;
    localparam int FRAME_BITS          = 10;

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter feeding the AVR USB bridge.
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   block     AVR flow control; high stops new frames from starting
//   data      byte to send, sampled on an accepted new_data
//   new_data  one-cycle send request
//   busy      high when a request would be dropped
//   tx        serial line, idle high, registered
module uart_tx
    import avionics_uart_pkg::*;
#(
    parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       block,
    input  logic [7:0] data,
    input  logic       new_data,
    output logic       busy,
    output logic       tx
);

    localparam int              CW      = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0]   CTR_MAX = CW'(CLK_PER_BIT - 1);

    state_t          state;
    logic [CW-1:0]   ctr;
    logic [2:0]      bit_ctr;
    logic [7:0]      shift;
    logic            block_q;
    logic            bit_end;

    assign bit_end = (ctr == CTR_MAX);

    // block_q resets high so nothing can be accepted until block is seen.
    assign busy = (state == IDLE) ? block_q : 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            block_q <= 1'b1;
            ctr     <= '0;
            bit_ctr <= '0;
            shift   <= '0;
        end else begin
            block_q <= block;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (new_data && !block_q) begin
                        shift   <= data;
                        ctr     <= '0;
                        bit_ctr <= '0;
                        state   <= START;
                        tx      <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        ctr   <= '0;
                        state <= DATA;
                        tx    <= shift[0];
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        ctr     <= '0;
                        shift   <= shift >> 1;
                        bit_ctr <= bit_ctr + 3'd1;
                        // tx is registered, so load the next bit from the
                        // pre-shift value to keep each bit exactly one period.
                        if (bit_ctr == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx <= shift[1];
                        end
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        ctr   <= '0;
                        state <= IDLE;
                    end else begin
                        ctr <= ctr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx with CLK_PER_BIT=4. Stimulus pushes bytes that
// must appear on tx; a monitor captures every frame sample by sample and
// compares against a waveform built from the popped byte.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int FLEN  = 10 * CPB;

    logic       clk;
    logic       rst;
    logic       block;
    logic [7:0] data;
    logic       new_data;
    logic       busy;
    logic       tx;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int frames_started = 0;
    int frames_done    = 0;
    int start_last     = 0;
    int start_prev     = 0;

    uart_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .block    (block),
        .data     (data),
        .new_data (new_data),
        .busy     (busy),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic            in_frame = 1'b0;
    int              idx      = 0;
    logic [FLEN-1:0] act_w;
    logic [FLEN-1:0] exp_w;
    logic [7:0]      eb;

    always @(negedge clk) begin
        if (!rst) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx == 1'b0) begin
                in_frame   = 1'b1;
                act_w      = '0;
                act_w[0]   = tx;
                idx        = 1;
                start_prev = start_last;
                start_last = cyc;
                frames_started++;
            end
        end else begin
            act_w[idx] = tx;
            idx++;
            if (idx == FLEN) begin
                in_frame = 1'b0;
                frames_done++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 64'(act_w), 64'h0);
                end else begin
                    eb = exp_q.pop_front();
                    for (int i = 0; i < FLEN; i++) begin
                        if (i / CPB == 0)      exp_w[i] = 1'b0;
                        else if (i / CPB == 9) exp_w[i] = 1'b1;
                        else                   exp_w[i] = eb[i / CPB - 1];
                    end
                    chk($sformatf("frame_%02h", eb), 64'(act_w), 64'(exp_w));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input logic [7:0] b, input bit expect_frame);
        @(negedge clk);
        data     = b;
        new_data = 1'b1;
        if (expect_frame) exp_q.push_back(b);
        @(negedge clk);
        new_data = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames_done < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("wait_frames", 64'(frames_done), 64'(n));
    endtask

    initial begin
        int cnt;
        int bad;
        int fs0;
        int fd0;

        rst = 1'b0; block = 1'b0; data = 8'h00; new_data = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx", 64'(tx), 64'd1);
        chk("reset_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("busy_first_cycle", 64'(busy), 64'd1);
        @(negedge clk);
        chk("busy_second_cycle", 64'(busy), 64'd0);
        chk("tx_idle", 64'(tx), 64'd1);

        // single byte 0xA5 and its busy window
        pulse(8'hA5, 1'b1);
        cnt = 0;
        while (busy && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_len_a5", 64'(cnt), 64'(FLEN));
        wait_frames(1);

        // back-to-back 0x00 then 0xFF on the first non-busy cycle
        pulse(8'h00, 1'b1);
        cnt = 0;
        while (busy && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        data = 8'hFF; new_data = 1'b1; exp_q.push_back(8'hFF);
        @(negedge clk);
        new_data = 1'b0;
        wait_frames(3);
        chk("b2b_gap", 64'(start_last - start_prev), 64'(FLEN + 1));

        // request while busy is dropped
        fs0 = frames_started; fd0 = frames_done;
        pulse(8'h55, 1'b1);
        repeat (10) @(negedge clk);
        pulse(8'h3C, 1'b0);
        wait_frames(fd0 + 1);
        repeat (60) @(negedge clk);
        chk("drop_frame_count", 64'(frames_started - fs0), 64'd1);

        // flow control
        block = 1'b1;
        @(negedge clk);
        chk("block_latency", 64'(busy), 64'd1);
        fs0 = frames_started;
        pulse(8'h12, 1'b0);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!tx || !busy) bad++;
        end
        chk("blocked_hold", 64'(bad), 64'd0);
        chk("blocked_no_frame", 64'(frames_started - fs0), 64'd0);
        block = 1'b0;
        repeat (2) @(negedge clk);
        chk("unblocked_busy", 64'(busy), 64'd0);
        fd0 = frames_done;
        pulse(8'h5A, 1'b1);
        repeat (10) @(negedge clk);
        block = 1'b1;
        wait_frames(fd0 + 1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!tx || !busy) bad++;
        end
        chk("block_after_frame", 64'(bad), 64'd0);
        block = 1'b0;
        repeat (2) @(negedge clk);

        // reset during data bit 3 of 0x96 (bit 3 is 0)
        pulse(8'h96, 1'b0);
        repeat (16) @(negedge clk);
        chk("pre_reset_bit3", 64'(tx), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_tx", 64'(tx), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fs0 = frames_started;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (!tx) bad++;
        end
        chk("no_residual", 64'(bad + frames_started - fs0), 64'd0);
        fd0 = frames_done;
        pulse(8'h81, 1'b1);
        wait_frames(fd0 + 1);
        repeat (5) @(negedge clk);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that consumes the byte stream from the debugging message generator and drives the TX line toward the AVR USB bridge. It accepts one byte per `new_data` pulse when not busy and serialises it as 8N1 (start bit, 8 data bits LSB first, stop bit). It also honours the AVR's flow-control `block` input and reports back-pressure on `busy`, which feeds the `tx_busy` input of the debugging stage.

## Interface
- `CLK_PER_BIT`, 50: clock cycles per serial bit (50 MHz / 1 Mbaud); legal range ≥ 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `block`  in  1  AVR flow control; high means no new frame may start.
- `data`  in  8  byte to send; sampled only on an accepted `new_data`.
- `new_data`  in  1  one-cycle request to send `data`.
- `busy`  out  1  high when a request would not be accepted.
- `tx`  out  1  serial line, idle high.

## Operation
- Reset values while `rst` is low: state IDLE, `tx`=1, `block_q`=1 (so `busy`=1), bit counter 0, cycle counter 0, shift register 0.
- `block_q` is `block` registered once. `busy` = `block_q` in IDLE, and 1 in every other state. `busy` is combinational from registered state only.
- States:
  - IDLE: `tx`=1. If `new_data` && !`block_q`, latch `data` into the shift register, clear counters, and go to START.
  - START: `tx`=0 for CLK_PER_BIT cycles, then go to DATA.
  - DATA: `tx` = shift[0]. After CLK_PER_BIT cycles, shift right. Increment the bit counter. After bit 7 completes, go to STOP.
  - STOP: `tx`=1 for CLK_PER_BIT cycles, then go to IDLE.
- The cycle counter is $clog2(CLK_PER_BIT) bits wide. It counts 0..CLK_PER_BIT-1 and wraps to 0 at each bit boundary. The bit counter is 3 bits and wraps 7→0 on entry to STOP.
- `new_data` while `busy`=1 is silently dropped. There is no queue and no error flag.
- `block` rising mid-frame does not abort the frame. It only prevents the next START.
- `new_data` in the same cycle that STOP ends (state still STOP) is dropped. The first acceptable cycle is the one after the return to IDLE.
- `rst` asserted mid-frame: `tx` goes to 1 immediately (asynchronously) and the byte is lost. No partial frame resumes after reset.
- `tx` is a registered output and must be glitch-free.

## Timing
- Accept at edge N (IDLE, `new_data`=1, `block_q`=0) → `busy`=1 and `tx`=0 from N+1.
- Start bit occupies cycles N+1..N+CLK_PER_BIT. Data bit k occupies the next CLK_PER_BIT cycles, in order k=0..7. Stop bit follows.
- The frame is 10·CLK_PER_BIT cycles. `busy` falls at N+10·CLK_PER_BIT+1 if `block_q`=0.
- Maximum throughput is one byte per 10·CLK_PER_BIT+1 cycles. This is compatible with the debugging stage, which pulses `new_data` whenever `busy` is low.
- `block` → `busy` latency is 1 cycle in IDLE.

## Structure
- The shared package `avionics_uart_pkg` holds:
  - the state encoding localparams (IDLE, START, DATA, STOP; 2 bits);
  - the default CLK_PER_BIT;
  - the frame-length constant (10 bits).
- A future `uart_rx` reuses the same package.
- Single module, no sub-module. The cycle counter and the shifter are both small enough to inline.

## Test plan
All scenarios use CLK_PER_BIT=4.
- Reset release with `block`=0: `busy`=1 in the first cycle after reset, 0 in the second; `tx`=1 throughout.
- Send 0xA5: `tx` holds each of 0,1,0,1,0,0,1,0,1,1 for exactly 4 cycles. `busy` is high for 40 cycles, then low.
- Back-to-back: pulse `new_data` on the first cycle `busy` is low, with 0x00 then 0xFF. This gives two contiguous frames separated by 1 idle-high cycle, with correct bit patterns.
- Drop while busy: pulse `new_data` with 0x3C mid-frame of 0x55. Only 0x55 appears on `tx`, and no extra frame follows.
- Flow control: hold `block`=1, pulse `new_data` with 0x12. `tx` stays 1 and `busy` stays 1. Raising `block` mid-frame of a prior byte completes that frame, then `busy` stays high.
- Reset mid-frame: assert `rst` low during data bit 3. `tx`=1 in the same cycle (async). After release, no residual bits are sent, and the next byte 0x81 transmits correctly.
